// File: rtl/fme_mmio_csr_pkg.sv
// fme_mmio_csr_pkg: shared types and constants for the FME MMIO-to-CSR bridge.
//   state_e        bridge FSM states
//   RESP_OKAY      AXI OKAY response code
//   RESP_SLVERR    AXI SLVERR response code
//   cmd_t          command captured from AW/AR (+W), sized by the CMD_* widths
package fme_mmio_csr_pkg;

   localparam int CMD_ADDR_W = 20;
   localparam int CMD_DATA_W = 64;
   localparam int CMD_ID_W   = 9;
   localparam int CMD_STRB_W = CMD_DATA_W / 8;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      WR_ADDR_DONE,
      WR_DRAIN,
      CSR_WR,
      WR_RESP,
      CSR_RD,
      RD_RESP,
      RD_ERR
   } state_e;

   typedef struct packed {
      logic [CMD_ID_W-1:0]   id;
      logic [CMD_ADDR_W-1:0] addr;
      logic [7:0]            len;
      logic [CMD_DATA_W-1:0] wdata;
      logic [CMD_STRB_W-1:0] wstrb;
      logic                  is_wr;
   } cmd_t;

endpackage

// File: rtl/fme_csr_tmo_cnt.sv
// fme_csr_tmo_cnt: CSR acknowledge timeout counter.
//   clk, rst_n   clock, async active-low reset
//   run          high while a CSR request is outstanding; low clears the count
//   expired      high in the TMO_CYC-th consecutive cycle of run without release
module fme_csr_tmo_cnt #(
   parameter int TMO_CYC = 512
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic expired
);

   localparam int CNT_W = $clog2(TMO_CYC + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb cnt_d = run ? cnt_q + 1'b1 : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign expired = run && (cnt_q == CNT_W'(TMO_CYC - 1));

endmodule

// File: rtl/fme_mmio_csr_bridge.sv
// fme_mmio_csr_bridge: AXI4-MM MMIO slave to single-outstanding FME CSR req/ack port.
//   clk, rst_n                         clock, async active-low reset
//   aw*/w*/b*                          AXI write channels (awlen != 0 -> drained, SLVERR)
//   ar*/r*                             AXI read channels  (arlen != 0 -> arlen+1 SLVERR beats)
//   csr_req/csr_wr/csr_addr/
//   csr_wdata/csr_wstrb                CSR command, held until csr_ack
//   csr_ack/csr_rdata                  one-cycle CSR completion
// Optional: define FME_CSR_TIMEOUT_EN to abort a CSR access with SLVERR after
// TMO_CYC cycles without csr_ack (reads then return all-ones).
module fme_mmio_csr_bridge
   import fme_mmio_csr_pkg::*;
#(
   parameter int ADDR_W  = CMD_ADDR_W,
   parameter int DATA_W  = CMD_DATA_W,
   parameter int ID_W    = CMD_ID_W,
   parameter int TMO_CYC = 512
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                awvalid,
   output logic                awready,
   input  logic [ID_W-1:0]     awid,
   input  logic [ADDR_W-1:0]   awaddr,
   input  logic [7:0]          awlen,
   input  logic                wvalid,
   output logic                wready,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   input  logic                wlast,
   output logic                bvalid,
   input  logic                bready,
   output logic [ID_W-1:0]     bid,
   output logic [1:0]          bresp,
   input  logic                arvalid,
   output logic                arready,
   input  logic [ID_W-1:0]     arid,
   input  logic [ADDR_W-1:0]   araddr,
   input  logic [7:0]          arlen,
   output logic                rvalid,
   input  logic                rready,
   output logic [ID_W-1:0]     rid,
   output logic [DATA_W-1:0]   rdata,
   output logic [1:0]          rresp,
   output logic                rlast,
   output logic                csr_req,
   output logic                csr_wr,
   output logic [ADDR_W-1:0]   csr_addr,
   output logic [DATA_W-1:0]   csr_wdata,
   output logic [DATA_W/8-1:0] csr_wstrb,
   input  logic                csr_ack,
   input  logic [DATA_W-1:0]   csr_rdata
);

   state_e              state_q, state_d;
   cmd_t                cmd_q, cmd_d;
   logic                wr_pri_q, wr_pri_d;
   logic                awready_q, awready_d;
   logic                arready_q, arready_d;
   logic                wready_q, wready_d;
   logic                csr_req_q, csr_req_d;
   logic                bvalid_q, bvalid_d;
   logic [1:0]          bresp_q, bresp_d;
   logic                rvalid_q, rvalid_d;
   logic [1:0]          rresp_q, rresp_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                rlast_q, rlast_d;
   logic                grant_rd, grant_wr, ok, tmo;

`ifdef FME_CSR_TIMEOUT_EN
   fme_csr_tmo_cnt #(.TMO_CYC(TMO_CYC)) u_tmo (
      .clk     (clk),
      .rst_n   (rst_n),
      .run     (csr_req_q),
      .expired (tmo)
   );
`else
   // No timeout in this build: the bridge waits for csr_ack indefinitely.
   assign tmo = (TMO_CYC < 0);
`endif

   // wr_pri_q=0 favours read when AW and AR collide; flips on every grant.
   assign grant_rd = arvalid && (!awvalid || !wr_pri_q);
   assign grant_wr = awvalid && !grant_rd;
   // An ack only counts while the request is actually on the port.
   assign ok       = csr_req_q && csr_ack;

   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      wr_pri_d  = wr_pri_q;
      awready_d = 1'b0;
      arready_d = 1'b0;
      wready_d  = 1'b0;
      csr_req_d = 1'b0;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      rvalid_d  = rvalid_q;
      rresp_d   = rresp_q;
      rdata_d   = rdata_q;
      rlast_d   = rlast_q;
      case (state_q)
         IDLE: if (grant_rd || grant_wr) begin
            // AXI holds the payload stable while valid is high, so it is
            // captured at grant; the ready pulse completes the handshake.
            wr_pri_d    = ~wr_pri_q;
            arready_d   = grant_rd;
            awready_d   = grant_wr;
            cmd_d.is_wr = grant_wr;
            cmd_d.id    = grant_rd ? arid : awid;
            cmd_d.addr  = grant_rd ? araddr : awaddr;
            cmd_d.len   = grant_rd ? arlen : awlen;
            state_d     = grant_rd ? (arlen == 8'd0 ? CSR_RD : RD_ERR)
                                   : (awlen == 8'd0 ? WR_ADDR_DONE : WR_DRAIN);
         end
         WR_ADDR_DONE: if (wready_q && wvalid) begin
            cmd_d.wdata = wdata;
            cmd_d.wstrb = wstrb;
            state_d     = CSR_WR;
         end else begin
            wready_d = 1'b1;
         end
         WR_DRAIN: if (wready_q && wvalid && wlast) begin
            bvalid_d = 1'b1;
            bresp_d  = RESP_SLVERR;
            state_d  = WR_RESP;
         end else begin
            wready_d = 1'b1;
         end
         CSR_WR, CSR_RD: if (ok || tmo) begin
            if (cmd_q.is_wr) begin
               bvalid_d = 1'b1;
               bresp_d  = ok ? RESP_OKAY : RESP_SLVERR;
               state_d  = WR_RESP;
            end else begin
               rvalid_d = 1'b1;
               rresp_d  = ok ? RESP_OKAY : RESP_SLVERR;
               rdata_d  = ok ? csr_rdata : '1;
               rlast_d  = 1'b1;
               state_d  = RD_RESP;
            end
         end else begin
            csr_req_d = 1'b1;
         end
         WR_RESP: if (bready) begin
            bvalid_d = 1'b0;
            state_d  = IDLE;
         end
         RD_RESP: if (rready) begin
            rvalid_d = 1'b0;
            state_d  = IDLE;
         end
         RD_ERR: if (!rvalid_q) begin
            rvalid_d = 1'b1;
            rresp_d  = RESP_SLVERR;
            rdata_d  = '0;
            rlast_d  = 1'b0;
         end else if (rready) begin
            // cmd.len doubles as the down-counting beat counter.
            if (rlast_q) begin
               rvalid_d = 1'b0;
               state_d  = IDLE;
            end else begin
               cmd_d.len = cmd_q.len - 8'd1;
               rlast_d   = (cmd_q.len == 8'd1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cmd_q     <= '0;
         wr_pri_q  <= 1'b0;
         awready_q <= 1'b0;
         arready_q <= 1'b0;
         wready_q  <= 1'b0;
         csr_req_q <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'b00;
         rvalid_q  <= 1'b0;
         rresp_q   <= 2'b00;
         rdata_q   <= '0;
         rlast_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         wr_pri_q  <= wr_pri_d;
         awready_q <= awready_d;
         arready_q <= arready_d;
         wready_q  <= wready_d;
         csr_req_q <= csr_req_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         rvalid_q  <= rvalid_d;
         rresp_q   <= rresp_d;
         rdata_q   <= rdata_d;
         rlast_q   <= rlast_d;
      end
   end

   assign awready   = awready_q;
   assign arready   = arready_q;
   assign wready    = wready_q;
   assign bvalid    = bvalid_q;
   assign bid       = cmd_q.id;
   assign bresp     = bresp_q;
   assign rvalid    = rvalid_q;
   assign rid       = cmd_q.id;
   assign rdata     = rdata_q;
   assign rresp     = rresp_q;
   assign rlast     = rlast_q;
   assign csr_req   = csr_req_q;
   assign csr_wr    = cmd_q.is_wr;
   assign csr_addr  = cmd_q.addr;
   assign csr_wdata = cmd_q.wdata;
   assign csr_wstrb = cmd_q.wstrb;

endmodule

// File: tb/tb_fme_mmio_csr_bridge.sv
// tb_fme_mmio_csr_bridge: randomized self-checking bench for fme_mmio_csr_bridge.
module tb_fme_mmio_csr_bridge;
   import fme_mmio_csr_pkg::*;

   localparam int LIM = 2000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
   logic [8:0]  awid, bid, arid, rid;
   logic [19:0] awaddr, araddr, csr_addr;
   logic [7:0]  awlen, arlen, wstrb, csr_wstrb;
   logic [63:0] wdata, rdata, csr_wdata, csr_rdata;
   logic [1:0]  bresp, rresp;
   logic        arvalid, arready, rvalid, rready, rlast;
   logic        csr_req, csr_wr, csr_ack;

   int          n_checks = 0;
   int          n_err = 0;
   int          ack_dly = 0;
   bit          rsp_en = 1'b1;
   bit          late_ack = 1'b0;
   bit          tmo_mode = 1'b0;
   logic [63:0] rsp_data = '0;
   int          req_cnt = 0;
   int          last_run = 0;
   logic        seen_wr;
   logic [19:0] seen_addr;
   logic [63:0] seen_wdata;
   logic [7:0]  seen_wstrb;
   int          grants[$];

   always #5 clk = ~clk;

   fme_mmio_csr_bridge #(.TMO_CYC(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
      .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
      .csr_req(csr_req), .csr_wr(csr_wr), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
      .csr_wstrb(csr_wstrb), .csr_ack(csr_ack), .csr_rdata(csr_rdata)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_ctrl"}, 64'({awready, wready, bvalid, arready, rvalid, rlast, csr_req, csr_wr}), 64'd0);
      check({tag, "_id_resp"}, 64'({bid, rid, bresp, rresp}), 64'd0);
      check({tag, "_data"}, 64'(|{rdata, csr_wdata, csr_addr, csr_wstrb}), 64'd0);
   endtask

   // CSR register-file stand-in: records each command and acks after ack_dly cycles.
   initial begin
      int  w, run;
      bit  prev;
      csr_ack = 1'b0;
      csr_rdata = '0;
      w = 0;
      run = 0;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (csr_req && !prev) begin
            req_cnt++;
            seen_wr = csr_wr;
            seen_addr = csr_addr;
            seen_wdata = csr_wdata;
            seen_wstrb = csr_wstrb;
         end
         if (csr_req) run++;
         else if (run != 0) begin
            last_run = run;
            run = 0;
         end
         prev = csr_req;
         if (csr_ack) begin
            csr_ack = 1'b0;
            csr_rdata = {$urandom, $urandom};
         end else if (late_ack) begin
            csr_ack = 1'b1;
            late_ack = 1'b0;
         end else if (csr_req && rsp_en) begin
            if (w >= ack_dly) begin
               csr_ack = 1'b1;
               csr_rdata = rsp_data;
               w = 0;
            end else w++;
         end
         if (!csr_req) w = 0;
      end
   end

   initial forever begin
      @(negedge clk);
      if (arready) grants.push_back(0);
      if (awready) grants.push_back(1);
   end

   task automatic do_read(input logic [8:0] id, input logic [19:0] addr, input logic [7:0] len,
                          input logic [63:0] data, input int dly, output int lat);
      int n, beats, base;
      bit done, first;
      @(negedge clk);
      ack_dly = dly;
      rsp_data = data;
      arvalid = 1'b1; arid = id; araddr = addr; arlen = len;
      lat = 0;
      n = 0;
      while (!arready && n < LIM) begin @(negedge clk); n++; lat++; end
      check("rd_ar_accept", 64'(n < LIM), 64'd1);
      base = req_cnt;
      @(negedge clk);
      lat++;
      arvalid = 1'b0;
      beats = 0; done = 1'b0; first = 1'b1; n = 0;
      while (!done && n < LIM) begin
         rready = ($urandom_range(0, 3) != 0);
         if (rvalid) first = 1'b0;
         if (rvalid && rready) begin
            check("rd_rid", 64'(rid), 64'(id));
            if (len == 8'd0) begin
               check("rd_rdata", rdata, tmo_mode ? '1 : data);
               check("rd_rresp", 64'(rresp), 64'(tmo_mode ? RESP_SLVERR : RESP_OKAY));
               check("rd_rlast", 64'(rlast), 64'd1);
            end else begin
               check("rd_err_rdata", rdata, 64'd0);
               check("rd_err_rresp", 64'(rresp), 64'(RESP_SLVERR));
               check("rd_err_rlast", 64'(rlast), 64'(beats == int'(len)));
            end
            beats++;
            done = (beats == int'(len) + 1);
         end
         @(negedge clk);
         n++;
         if (first) lat++;
      end
      rready = 1'b0;
      check("rd_complete", 64'(done), 64'd1);
      check("rd_idle_rvalid", 64'(rvalid), 64'd0);
      check("rd_csr_count", 64'(req_cnt - base), 64'(len == 8'd0));
      if (len == 8'd0) begin
         check("rd_csr_wr", 64'(seen_wr), 64'd0);
         check("rd_csr_addr", 64'(seen_addr), 64'(addr));
      end
   endtask

   task automatic do_write(input logic [8:0] id, input logic [19:0] addr, input logic [7:0] len,
                           input logic [63:0] data, input logic [7:0] strb, input int dly);
      int n, base;
      bit done;
      @(negedge clk);
      ack_dly = dly;
      awvalid = 1'b1; awid = id; awaddr = addr; awlen = len;
      wvalid = 1'b1; wdata = data; wstrb = strb; wlast = (len == 8'd0);
      n = 0;
      while (!awready && n < LIM) begin @(negedge clk); n++; end
      check("wr_aw_accept", 64'(n < LIM), 64'd1);
      check("wr_wready_before_aw", 64'(wready), 64'd0);
      base = req_cnt;
      @(negedge clk);
      awvalid = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         wdata = (b == 0) ? data : {$urandom, $urandom};
         wlast = (b == int'(len));
         n = 0;
         while (!wready && n < LIM) begin @(negedge clk); n++; end
         check("wr_w_accept", 64'(n < LIM), 64'd1);
         @(negedge clk);
      end
      wvalid = 1'b0; wlast = 1'b0;
      done = 1'b0; n = 0;
      while (!done && n < LIM) begin
         bready = ($urandom_range(0, 3) != 0);
         if (bvalid && bready) begin
            check("wr_bid", 64'(bid), 64'(id));
            check("wr_bresp", 64'(bresp),
                  64'((len != 8'd0 || tmo_mode) ? RESP_SLVERR : RESP_OKAY));
            done = 1'b1;
         end
         @(negedge clk);
         n++;
      end
      bready = 1'b0;
      check("wr_complete", 64'(done), 64'd1);
      check("wr_idle_bvalid", 64'(bvalid), 64'd0);
      check("wr_csr_count", 64'(req_cnt - base), 64'(len == 8'd0));
      if (len == 8'd0) begin
         check("wr_csr_wr", 64'(seen_wr), 64'd1);
         check("wr_csr_addr", 64'(seen_addr), 64'(addr));
         check("wr_csr_wdata", seen_wdata, data);
         check("wr_csr_wstrb", 64'(seen_wstrb), 64'(strb));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int lat, lat2, n;
      logic [3:0] ord;
      rst_n = 1'b0;
      {awvalid, wvalid, wlast, bready, arvalid, rready} = '0;
      {awid, arid, awaddr, araddr, awlen, arlen, wstrb} = '0;
      wdata = '0;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      rst_n = 1'b1;

      do_write(9'd5, 20'h100, 8'd0, 64'hDEAD_BEEF, 8'hFF, 2);
      do_read(9'd3, 20'h08, 8'd0, 64'h1234, 0, lat);
      check("rd_min_latency", 64'(lat), 64'd3);

      for (int r = 0; r < 2; r++) begin
         grants.delete();
         fork
            do_read(9'h011, 20'h200, 8'd0, {$urandom, $urandom}, 1, lat);
            do_write(9'h022, 20'h210, 8'd0, {$urandom, $urandom}, 8'h0F, 1);
         join
         ord = '0;
         foreach (grants[i]) ord = {ord[2:0], grants[i] != 0};
         check("arb_grant_count", 64'(grants.size()), 64'd2);
         check("arb_order", 64'(ord), 64'b01);
      end

      do_read(9'h1A, 20'h40, 8'd3, 64'hFFFF, 0, lat);
      do_write(9'h22, 20'h48, 8'd1, 64'h5555, 8'h3C, 0);
      do_read(9'h1FF, 20'hFFFF8, 8'd255, 64'h0, 0, lat);

      for (int t = 0; t < 40; t++) begin
         logic [7:0] len;
         len = ($urandom_range(0, 9) < 7) ? 8'd0 : 8'($urandom_range(1, 6));
         if ($urandom_range(0, 1) != 0)
            do_read(9'($urandom), 20'($urandom), len, {$urandom, $urandom}, $urandom_range(0, 4), lat);
         else
            do_write(9'($urandom), 20'($urandom), len, {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 4));
      end

`ifdef FME_CSR_TIMEOUT_EN
      rsp_en = 1'b0;
      tmo_mode = 1'b1;
      do_read(9'h07, 20'h300, 8'd0, 64'h0, 0, lat);
      check("tmo_req_cycles", 64'(last_run), 64'd16);
      tmo_mode = 1'b0;
      late_ack = 1'b1;
      repeat (4) @(negedge clk);
      check("tmo_late_ack_quiet", 64'({rvalid, bvalid, csr_req}), 64'd0);
      rsp_en = 1'b1;
      do_read(9'h08, 20'h308, 8'd0, 64'hCAFE, 1, lat);
`endif

      rsp_en = 1'b0;
      @(negedge clk);
      arvalid = 1'b1; arid = 9'h0AB; araddr = 20'h500; arlen = 8'd0;
      n = 0;
      while (!arready && n < LIM) begin @(negedge clk); n++; end
      @(negedge clk);
      arvalid = 1'b0;
      while (!csr_req && n < LIM) begin @(negedge clk); n++; end
      check("abort_req_seen", 64'(csr_req), 64'd1);
      rst_n = 1'b0;
      #1;
      check_outputs_zero("abort");
      @(negedge clk);
      rst_n = 1'b1;
      rsp_en = 1'b1;
      repeat (3) @(negedge clk);
      check("abort_no_resp", 64'({rvalid, bvalid}), 64'd0);
      do_read(9'h0AC, 20'h508, 8'd0, 64'h0123_4567_89AB_CDEF, 1, lat2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
